// File: rtl/pio_event_poller.sv
// Avalon-MM master that periodically polls an edge-capture PIO, clears the captured
// edges and queues {capture, level} events for a valid/ready consumer.
module pio_event_poller #(
  parameter int unsigned POLL_DIV   = 1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic        evt_overflow,
  input  logic        ovf_clr,
  output logic        irq
);

  localparam int unsigned TMR_W  = $clog2(POLL_DIV);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam logic [1:0]  REG_LEVEL = 2'd0;
  localparam logic [1:0]  REG_EDGE  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CAP,
    S_WAIT_CAP,
    S_CLR,
    S_RD_DAT,
    S_WAIT_DAT,
    S_PUSH
  } state_e;

  state_e state_q, state_d;

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       cap_q, lvl_q;
  logic [1:0]       m_address_q, m_address_d;
  logic             m_chipselect_q, m_chipselect_d;
  logic             m_write_n_q, m_write_n_d;
  logic             ovf_q;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0] count_c;
  logic             empty_c, full_c, pop_c, push_c, push_ok_c, drop_c;

  logic             unused_rdata;
  assign unused_rdata = ^m_readdata[31:8];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the timer only runs while idle
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (tmr_q == '0) begin
          tmr_d = TMR_W'(POLL_DIV - 1);
          if (enable) state_d = S_RD_CAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RD_CAP:   state_d = S_WAIT_CAP;
      S_WAIT_CAP: state_d = (m_readdata[7:0] == 8'h00) ? S_IDLE : S_CLR;
      S_CLR:      state_d = S_RD_DAT;
      S_RD_DAT:   state_d = S_WAIT_DAT;
      S_WAIT_DAT: state_d = S_PUSH;
      S_PUSH:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registers line up with it
  always_comb begin
    m_address_d    = REG_LEVEL;
    m_chipselect_d = 1'b0;
    m_write_n_d    = 1'b1;
    unique case (state_d)
      S_RD_CAP: m_address_d = REG_EDGE;
      S_CLR: begin
        m_address_d    = REG_EDGE;
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q          <= TMR_W'(POLL_DIV - 1);
      cap_q          <= 8'h00;
      lvl_q          <= 8'h00;
      m_address_q    <= REG_LEVEL;
      m_chipselect_q <= 1'b0;
      m_write_n_q    <= 1'b1;
    end else begin
      tmr_q          <= tmr_d;
      m_address_q    <= m_address_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_n_q    <= m_write_n_d;
      if (state_q == S_WAIT_CAP) cap_q <= m_readdata[7:0];
      if (state_q == S_WAIT_DAT) lvl_q <= m_readdata[7:0];
    end
  end

  // Event FIFO: a pop frees the head before a same-cycle push is judged
  assign count_c   = wr_ptr_q - rd_ptr_q;
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (count_c == PTR_W'(FIFO_DEPTH));
  assign pop_c     = evt_ready && !empty_c;
  assign push_c    = (state_q == S_PUSH);
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign drop_c    = push_c && full_c && !pop_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 16'h0000;
    end else begin
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok_c) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= {cap_q, lvl_q};
        wr_ptr_q                    <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop_c) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign m_address    = m_address_q;
  assign m_chipselect = m_chipselect_q;
  assign m_write_n    = m_write_n_q;
  assign m_writedata  = 32'h0000_0000;
  assign evt_valid    = !empty_c;
  assign irq          = !empty_c;
  assign evt_data     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_pio_event_poller.sv
// Bench for pio_event_poller: edge-capture PIO slave model, poll/event reference model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_pio_event_poller;

  localparam int unsigned DIV   = 8;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'h0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [15:0] evt_data;
  logic        evt_overflow;
  logic        ovf_clr = 1'b0;
  logic        irq;

  pio_event_poller #(.POLL_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // PIO slave: in_port level, rising-edge capture cleared by any write to reg 3
  logic [7:0] in_port = 8'h00;
  logic [7:0] in_prev = 8'h00;
  logic [7:0] s_cap   = 8'h00;

  always @(posedge clk) begin
    in_prev <= in_port;
    if (m_chipselect && !m_write_n && m_address == 2'd3) s_cap <= 8'h00;
    else s_cap <= s_cap | (in_port & ~in_prev);
    case (m_address)
      2'd0:    m_readdata <= {24'h0, in_port};
      2'd3:    m_readdata <= {24'h0, s_cap};
      default: m_readdata <= 32'h0;
    endcase
  end

  // Reference model: m_pos is the bus cycle within a poll (0 = idle, 1..6 = steps)
  int          m_pos = 0;
  int          m_tmr = DIV - 1;
  logic [7:0]  m_cap = 8'h00;
  logic [7:0]  m_lvl = 8'h00;
  logic        m_ovf = 1'b0;
  logic [15:0] mq[$];
  int          n_push_att = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_pos = 0;
        m_tmr = DIV - 1;
        m_ovf = 1'b0;
        mq.delete();
      end else begin
        bit popped;
        popped = evt_ready && (mq.size() != 0);
        if (popped) void'(mq.pop_front());
        if (m_pos == 6) begin
          n_push_att++;
          if (mq.size() < DEPTH) mq.push_back({m_cap, m_lvl});
          else m_ovf = 1'b1;
        end else if (ovf_clr) begin
          m_ovf = 1'b0;
        end
        case (m_pos)
          0: begin
            if (m_tmr == 0) begin
              m_tmr = DIV - 1;
              if (enable) m_pos = 1;
            end else begin
              m_tmr--;
            end
          end
          1: begin m_cap = s_cap; m_pos = 2; end
          2: m_pos = (m_cap == 8'h00) ? 0 : 3;
          4: begin m_lvl = in_port; m_pos = 5; end
          6: m_pos = 0;
          default: m_pos = m_pos + 1;
        endcase
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("m_address", 32'(m_address), (m_pos == 1 || m_pos == 3) ? 32'd3 : 32'd0);
    check("m_chipselect", 32'(m_chipselect), 32'(m_pos == 3));
    check("m_write_n", 32'(m_write_n), 32'(m_pos != 3));
    check("m_writedata", m_writedata, 32'h0);
    check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
    check("irq", 32'(irq), 32'(mq.size() != 0));
    check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    if (mq.size() != 0) check("evt_data", 32'(evt_data), 32'(mq[0]));
    if (m_address == 2'd3 && !m_chipselect) rd_cnt++;
    if (m_chipselect && !m_write_n) wr_cnt++;
  end

  task automatic inject(input logic [7:0] val);
    @(negedge clk) in_port = 8'h00;
    @(negedge clk) in_port = val;
  endtask

  task automatic wait_push(input string nm);
    int start;
    int i;
    start = n_push_att;
    i = 0;
    while (n_push_att == start && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({nm, "_push_timeout"}, 32'(n_push_att != start), 32'd1);
  endtask

  task automatic wait_pos(input int p, input string nm);
    int i;
    i = 0;
    while (m_pos != p && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({nm, "_step_timeout"}, 32'(m_pos == p), 32'd1);
  endtask

  task automatic drain(input logic [15:0] e [DEPTH], input string nm);
    evt_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      check({nm, "_valid"}, 32'(evt_valid), 32'd1);
      check({nm, "_data"}, 32'(evt_data), 32'(e[i]));
      @(negedge clk);
    end
    evt_ready = 1'b0;
    check({nm, "_empty"}, 32'(evt_valid), 32'd0);
  endtask

  logic [15:0] exp4 [DEPTH];

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // 1: idle polls with nothing captured
    reset_n = 1'b1;
    rd_cnt  = 0;
    wr_cnt  = 0;
    repeat (7) @(negedge clk);
    check("t1_before_poll", 32'(m_address), 32'd0);
    @(negedge clk);
    check("t1_first_poll", 32'(m_address), 32'd3);
    repeat (32) @(negedge clk);
    #1;
    check("t1_reads", 32'(rd_cnt), 32'd4);
    check("t1_writes", 32'(wr_cnt), 32'd0);
    check("t1_valid", 32'(evt_valid), 32'd0);

    // 2: single edge on bit 2
    inject(8'h04);
    wait_push("t2");
    #1;
    check("t2_data", 32'(evt_data), 32'h0404);
    check("t2_irq", 32'(irq), 32'd1);
    check("t2_writes", 32'(wr_cnt), 32'd1);
    repeat (3) @(negedge clk);
    check("t2_irq_held", 32'(irq), 32'd1);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("t2_popped", 32'(irq), 32'd0);

    // 3: consumer already ready
    evt_ready = 1'b1;
    inject(8'h81);
    wait_push("t3");
    check("t3_data", 32'(evt_data), 32'h8181);
    check("t3_valid", 32'(evt_valid), 32'd1);
    @(negedge clk);
    check("t3_empty", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // 4: five events into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      inject(8'(1 << i));
      wait_push("t4");
    end
    check("t4_ovf", 32'(evt_overflow), 32'd1);
    check("t4_head", 32'(evt_data), 32'h0101);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(evt_overflow), 32'd0);
    exp4 = '{16'h0101, 16'h0202, 16'h0404, 16'h0808};
    drain(exp4, "t4_drain");

    // 5: push while full with a pop in the same cycle
    inject(8'h03); wait_push("t5");
    inject(8'h05); wait_push("t5");
    inject(8'h09); wait_push("t5");
    inject(8'h11); wait_push("t5");
    inject(8'h21);
    wait_pos(6, "t5");
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("t5_ovf", 32'(evt_overflow), 32'd0);
    exp4 = '{16'h0505, 16'h0909, 16'h1111, 16'h2121};
    drain(exp4, "t5_drain");

    // 6: reset during the clear write, with one event pending
    inject(8'h02);
    wait_push("t6");
    check("t6_pending", 32'(evt_data), 32'h0202);
    inject(8'h40);
    wait_pos(3, "t6");
    check("t6_in_clr", 32'(m_chipselect), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_addr", 32'(m_address), 32'd0);
    check("t6_rst_cs", 32'(m_chipselect), 32'd0);
    check("t6_rst_wn", 32'(m_write_n), 32'd1);
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    check("t6_before_poll", 32'(m_address), 32'd0);
    @(negedge clk);
    check("t6_first_poll", 32'(m_address), 32'd3);
    wait_push("t6_after");
    check("t6_event", 32'(evt_data), 32'h4040);

    repeat (4) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
